sseg_scan_mux: RTL and testbench



---
 rtl/sseg_pkg.sv | 16 +
 rtl/sseg_tick_gen.sv | 30 +++
 rtl/sseg_scan_mux.sv | 115 +++++++++++
 tb/tb_sseg_scan_mux.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
// Segment and anode signals are active-low throughout.
package sseg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t        SEG_OFF    = 8'hFF;
    localparam logic [7:0]  AN_OFF     = 8'hFF;
    localparam int unsigned MAX_DIGITS = 8;

    typedef enum logic {
        ON,
        GAP
    } scan_state_t;

endpackage

// File: rtl/sseg_tick_gen.sv
// Refresh prescaler: pulses tick for one cycle every TICK_DIV enabled cycles.
// Counting freezes while en is low.
module sseg_tick_gen
    import sseg_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned   PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (en) begin
            if (pcnt == PLAST) pcnt <= '0;
            else               pcnt <= pcnt + 1'b1;
        end
    end

    assign tick = en && (pcnt == PLAST);

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed common-anode driver for 1..8 digits with an inter-digit blanking gap.
// Optional PWM dimming through the bright port when SSEG_MUX_DIMMING_EN is defined.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned GAP_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic [DIGITS*8-1:0]   seg_in,
    input  logic [DIGITS-1:0]     blank,
`ifdef SSEG_MUX_DIMMING_EN
    input  logic [3:0]            bright,
`endif
    output logic [7:0]            an,
    output seg_t                  sseg,
    output logic [2:0]            digit_idx,
    output logic                  frame_done
);

    localparam logic [2:0]    LAST  = 3'(DIGITS - 1);
    localparam int unsigned   GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GLAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

    scan_state_t   state, state_nxt;
    logic [GW-1:0] gcnt;
    logic          tick;
    logic          wrap;
    logic          lit;
    logic [7:0]    an_d;
    seg_t          sseg_d;

    sseg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    assign wrap = up ? (digit_idx == LAST) : (digit_idx == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick && wrap;
            if (tick) begin
                if (up) digit_idx <= wrap ? 3'd0 : digit_idx + 3'd1;
                else    digit_idx <= wrap ? LAST : digit_idx - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ON;
            gcnt  <= '0;
        end else if (en) begin
            state <= state_nxt;
            gcnt  <= (state == GAP) ? gcnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ON:      if (tick && (GAP_CYC > 0)) state_nxt = GAP;
            GAP:     if (gcnt == GLAST)         state_nxt = ON;
            default: state_nxt = ON;
        endcase
    end

`ifdef SSEG_MUX_DIMMING_EN
    logic [3:0] phase;

    always_ff @(posedge clk) begin
        if (rst)              phase <= '0;
        else if (state == ON) phase <= phase + 4'd1;
    end

    // Full scale is treated as always lit so bright=15 gives no dark phase.
    assign lit = (bright == 4'hF) || (phase < bright);
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        an_d   = AN_OFF;
        sseg_d = SEG_OFF;
        if (state == ON && lit) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                if (digit_idx == 3'(k) && !blank[k]) begin
                    an_d[k] = 1'b0;
                    sseg_d  = seg_in[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an   <= AN_OFF;
            sseg <= SEG_OFF;
        end else begin
            an   <= an_d;
            sseg <= sseg_d;
        end
    end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux: 4-digit scanner with a 1-cycle gap,
// plus a 3-digit gapless instance sharing clock, reset and enable.
module tb_sseg_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        up  = 1'b1;
    logic [31:0] seg_in = 32'hC0F9A4B0;
    logic [3:0]  blank  = 4'b0000;
    logic [7:0]  an, sseg;
    logic [2:0]  digit_idx;
    logic        frame_done;

    logic        up2 = 1'b1;
    logic [23:0] seg_in2 = 24'hA4F9C0;
    logic [2:0]  blank2  = 3'b000;
    logic [7:0]  an2, sseg2;
    logic [2:0]  digit_idx2;
    logic        frame_done2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sseg_scan_mux #(.DIGITS(4), .TICK_DIV(4), .GAP_CYC(1)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .seg_in(seg_in), .blank(blank),
        .an(an), .sseg(sseg), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    sseg_scan_mux #(.DIGITS(3), .TICK_DIV(4), .GAP_CYC(0)) dut3 (
        .clk(clk), .rst(rst), .en(en), .up(up2), .seg_in(seg_in2), .blank(blank2),
        .an(an2), .sseg(sseg2), .digit_idx(digit_idx2), .frame_done(frame_done2)
    );

    // Hand-derived per-cycle expectations after reset release (cycle 1..20).
    logic [7:0] an_up [20] = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD, 8'hFF, 8'hFB,
                               8'hFB, 8'hFB, 8'hFF, 8'hF7, 8'hF7, 8'hF7, 8'hFF, 8'hFE, 8'hFE, 8'hFE};
    logic [7:0] sg_up [20] = '{8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hFF, 8'hA4, 8'hA4, 8'hA4, 8'hFF, 8'hF9,
                               8'hF9, 8'hF9, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hB0, 8'hB0, 8'hB0};
    logic [7:0] an_dn [20] = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hF7, 8'hF7, 8'hF7, 8'hFF, 8'hFB,
                               8'hFB, 8'hFB, 8'hFF, 8'hFD, 8'hFD, 8'hFD, 8'hFF, 8'hFE, 8'hFE, 8'hFE};
    logic [7:0] sg_dn [20] = '{8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hF9,
                               8'hF9, 8'hF9, 8'hFF, 8'hA4, 8'hA4, 8'hA4, 8'hFF, 8'hB0, 8'hB0, 8'hB0};
    logic [2:0] ix_up [20] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2,
                               3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    logic [2:0] ix_dn [20] = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2,
                               3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3};
    // 3-digit gapless instance: digit 0,1,2 for 4 cycles each, then 0,1 again.
    logic [7:0] an_3 [20]  = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFB, 8'hFB,
                               8'hFB, 8'hFB, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFD, 8'hFD};
    logic [7:0] sg_3 [20]  = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hA4, 8'hA4,
                               8'hA4, 8'hA4, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hF9, 8'hF9, 8'hF9};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, c, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        chk("rst_an", 0, an, 8'hFF);
        chk("rst_sseg", 0, sseg, 8'hFF);
        chk("rst_idx", 0, 8'(digit_idx), 8'h00);
        chk("rst_fd", 0, 8'(frame_done), 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        step();
        en = 1'b1;

        // Ascending scan, both instances.
        up = 1'b1;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            step();
            chk("up_an", c, an, an_up[c-1]);
            chk("up_sseg", c, sseg, sg_up[c-1]);
            chk("up_idx", c, 8'(digit_idx), 8'(ix_up[c-1]));
            chk("up_fd", c, 8'(frame_done), (c == 16) ? 8'h01 : 8'h00);
            chk("d3_an", c, an2, an_3[c-1]);
            chk("d3_sseg", c, sseg2, sg_3[c-1]);
            chk("d3_fd", c, 8'(frame_done2), (c == 12) ? 8'h01 : 8'h00);
        end

        // Descending scan.
        up = 1'b0;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            step();
            chk("dn_an", c, an, an_dn[c-1]);
            chk("dn_sseg", c, sseg, sg_dn[c-1]);
            chk("dn_idx", c, 8'(digit_idx), 8'(ix_dn[c-1]));
            chk("dn_fd", c, 8'(frame_done), (c == 4 || c == 20) ? 8'h01 : 8'h00);
        end

        // Digit 2 blanked.
        up = 1'b1;
        blank = 4'b0100;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            step();
            chk("blk_an", c, an, (c >= 10 && c <= 12) ? 8'hFF : an_up[c-1]);
            chk("blk_sseg", c, sseg, (c >= 10 && c <= 12) ? 8'hFF : sg_up[c-1]);
        end
        blank = 4'b0000;

        // Freeze at index 1; pattern change on the held digit passes through.
        do_reset();
        for (int c = 1; c <= 6; c++) step();
        chk("hold_pre_an", 6, an, 8'hFD);
        en = 1'b0;
        for (int h = 0; h < 20; h++) begin
            if (h == 10) seg_in = 32'hC0F980B0;
            step();
            chk("hold_an", h, an, 8'hFD);
            chk("hold_idx", h, 8'(digit_idx), 8'h01);
            chk("hold_sseg", h, sseg, (h >= 10) ? 8'h80 : 8'hA4);
        end
        en = 1'b1;
        step();
        chk("resume_an", 1, an, 8'hFD);
        chk("resume_idx", 1, 8'(digit_idx), 8'h01);
        step();
        chk("resume_an", 2, an, 8'hFD);
        chk("resume_idx", 2, 8'(digit_idx), 8'h02);
        step();
        chk("resume_an", 3, an, 8'hFF);
        step();
        chk("resume_an", 4, an, 8'hFB);
        chk("resume_sseg", 4, sseg, 8'hF9);
        seg_in = 32'hC0F9A4B0;

        // Reset asserted mid-slot at index 2.
        do_reset();
        for (int c = 1; c <= 10; c++) step();
        chk("mid_pre_an", 10, an, 8'hFB);
        rst = 1'b1;
        step();
        chk("mid_an", 0, an, 8'hFF);
        chk("mid_sseg", 0, sseg, 8'hFF);
        chk("mid_idx", 0, 8'(digit_idx), 8'h00);
        chk("mid_fd", 0, 8'(frame_done), 8'h00);
        rst = 1'b0;
        step();
        chk("mid_an", 1, an, 8'hFE);
        chk("mid_sseg", 1, sseg, 8'hB0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
